verinject_serial_fault_tester: RTL and testbench

// - Serial single-bit fault-injection sequencer for verinject fault-injection campaigns.
// - Drives the 32-bit injector-state bus consumed by the injected copy of the DUT (*__injected) and by the sim monitor.
// - Sweeps bit indices 0..TOTAL_BITS-1, flipping one bit per injection slot.
// - Publishes a free-running 48-bit cycle counter.

---
 rtl/verinject_serial_fault_tester.sv | 155 +++++++++++++++
 tb/tb_verinject_serial_fault_tester.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/verinject_serial_fault_tester.sv
// ---------------------------------------------------------------------------
// verinject_serial_fault_tester
//
// Serial single-bit fault-injection sequencer. It walks bit indices
// 0..TOTAL_BITS-1 and presents one index per injection slot on the
// injector-state bus. That bus is consumed by the injected DUT copy and by
// the simulation monitor. Outside an injection slot the bus carries
// IDLE_CODE. A free-running 48-bit cycle counter is published alongside.
//
// Optional feature macro: VERINJECT_SINGLE_PASS_EN
//   When defined, the sequencer stops after one full sweep. It parks in DONE
//   with IDLE_CODE on the bus and raises sweep_done.
//   When undefined, the sweep repeats indefinitely and there is no
//   sweep_done port.
//
// Ports
//   clock                      in   1   single clock, rising edge
//   reset                      in   1   synchronous, active-high reset
//   enable                     in   1   1 = schedule advances, 0 = paused
//   verinject__injector_state  out  32  bit index to flip, or IDLE_CODE
//   cycle_number               out  48  free-running cycle counter
//   sweep_count                out  16  completed sweeps, saturating
//   sweep_done                 out  1   single-pass build only
// ---------------------------------------------------------------------------
module verinject_serial_fault_tester #(
  parameter int unsigned TOTAL_BITS  = 96,
  parameter int unsigned START_DELAY = 16,
  parameter int unsigned INTERVAL    = 8,
  parameter logic [31:0] IDLE_CODE   = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] verinject__injector_state,
  output logic [47:0] cycle_number,
`ifdef VERINJECT_SINGLE_PASS_EN
  output logic [15:0] sweep_count,
  output logic        sweep_done
`else
  output logic [15:0] sweep_count
`endif
);

  typedef enum logic [1:0] {
    ST_START,
    ST_WAIT,
`ifdef VERINJECT_SINGLE_PASS_EN
    ST_INJECT,
    ST_DONE
`else
    ST_INJECT
`endif
  } state_t;

  localparam logic [31:0] LAST_BIT     = 32'(TOTAL_BITS - 1);
  localparam logic [31:0] DELAY_RELOAD = 32'(START_DELAY);
  localparam logic [31:0] WAIT_RELOAD  = 32'(INTERVAL - 1);
  localparam bit          BACK_TO_BACK = (INTERVAL == 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] bit_idx_reg, bit_idx_next;
  logic [31:0] inj_reg, inj_next;
  logic [47:0] cycle_reg;
  logic [15:0] sweep_reg, sweep_next;
  logic        last_bit;
`ifdef VERINJECT_SINGLE_PASS_EN
  logic        done_reg, done_next;
`endif

  assign last_bit = (bit_idx_reg == LAST_BIT);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    sweep_next   = sweep_reg;
`ifdef VERINJECT_SINGLE_PASS_EN
    done_next    = done_reg;
`endif
    case (state_reg)
      // START and WAIT share the countdown. The slot fires on the edge
      // where the count would expire. A count of 0 can only occur after a
      // paused back-to-back schedule, and it also fires at once.
      ST_START, ST_WAIT: begin
        if (enable) begin
          if (cnt_reg <= 32'd1) begin
            state_next = ST_INJECT;
          end else begin
            cnt_next = cnt_reg - 32'd1;
          end
        end
      end
      // A registered INJECT cycle always completes, even if enable has
      // dropped. The index advances and the sweep bookkeeping happens on
      // the edge that leaves this cycle.
      ST_INJECT: begin
        bit_idx_next = last_bit ? 32'd0 : bit_idx_reg + 32'd1;
        if (last_bit && (sweep_reg != 16'hFFFF)) begin
          sweep_next = sweep_reg + 16'd1;
        end
`ifdef VERINJECT_SINGLE_PASS_EN
        if (last_bit) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else
`endif
        if (enable && BACK_TO_BACK) begin
          state_next = ST_INJECT;
        end else begin
          state_next = ST_WAIT;
          cnt_next   = WAIT_RELOAD;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase

    // The bus shows the index that the next state will be injecting.
    inj_next = (state_next == ST_INJECT) ? bit_idx_next : IDLE_CODE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_START;
      cnt_reg     <= DELAY_RELOAD;
      bit_idx_reg <= 32'd0;
      inj_reg     <= IDLE_CODE;
      cycle_reg   <= 48'd0;
      sweep_reg   <= 16'd0;
`ifdef VERINJECT_SINGLE_PASS_EN
      done_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      inj_reg     <= inj_next;
      cycle_reg   <= cycle_reg + 48'd1;
      sweep_reg   <= sweep_next;
`ifdef VERINJECT_SINGLE_PASS_EN
      done_reg    <= done_next;
`endif
    end
  end

  assign verinject__injector_state = inj_reg;
  assign cycle_number              = cycle_reg;
  assign sweep_count               = sweep_reg;
`ifdef VERINJECT_SINGLE_PASS_EN
  assign sweep_done                = done_reg;
`endif

endmodule

// File: tb/tb_verinject_serial_fault_tester.sv
// Directed bench for verinject_serial_fault_tester.
//   dut0: default parameters (reset, schedule, sweep wrap, pause, mid-sweep reset)
//   dut1: TOTAL_BITS=4, INTERVAL=1, START_DELAY=1 (back-to-back injection)
//   dut2: TOTAL_BITS=4, INTERVAL=2, START_DELAY=1 (single-pass scenario)
module tb_verinject_serial_fault_tester;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_a, en_a, rst_b;
  logic [31:0] inj0, inj1, inj2;
  logic [47:0] cyc0, cyc1, cyc2;
  logic [15:0] sw0, sw1, sw2;
`ifdef VERINJECT_SINGLE_PASS_EN
  logic        done0, done1, done2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  verinject_serial_fault_tester dut0 (
    .clock(clk), .reset(rst_a), .enable(en_a),
    .verinject__injector_state(inj0), .cycle_number(cyc0),
`ifdef VERINJECT_SINGLE_PASS_EN
    .sweep_count(sw0), .sweep_done(done0)
`else
    .sweep_count(sw0)
`endif
  );

  verinject_serial_fault_tester #(.TOTAL_BITS(4), .START_DELAY(1), .INTERVAL(1)) dut1 (
    .clock(clk), .reset(rst_b), .enable(1'b1),
    .verinject__injector_state(inj1), .cycle_number(cyc1),
`ifdef VERINJECT_SINGLE_PASS_EN
    .sweep_count(sw1), .sweep_done(done1)
`else
    .sweep_count(sw1)
`endif
  );

  verinject_serial_fault_tester #(.TOTAL_BITS(4), .START_DELAY(1), .INTERVAL(2)) dut2 (
    .clock(clk), .reset(rst_b), .enable(1'b1),
    .verinject__injector_state(inj2), .cycle_number(cyc2),
`ifdef VERINJECT_SINGLE_PASS_EN
    .sweep_count(sw2), .sweep_done(done2)
`else
    .sweep_count(sw2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Default schedule: injection k at cycle 16 + 8k, index k mod 96.
  function automatic logic [31:0] exp0(input int c);
    int k;
    if (c < 16 || ((c - 16) % 8) != 0) return IDLE;
    k = (c - 16) / 8;
`ifdef VERINJECT_SINGLE_PASS_EN
    if (k >= 96) return IDLE;
`endif
    return 32'(k % 96);
  endfunction

  function automatic logic [31:0] exp1(input int c);
`ifdef VERINJECT_SINGLE_PASS_EN
    if (c > 4) return IDLE;
`endif
    return 32'((c - 1) % 4);
  endfunction

  function automatic logic [31:0] exp2(input int c);
    int k;
    if ((c % 2) == 0) return IDLE;
    k = (c - 1) / 2;
`ifdef VERINJECT_SINGLE_PASS_EN
    if (k >= 4) return IDLE;
`endif
    return 32'(k % 4);
  endfunction

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    en_a  = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_inj0", 64'(inj0), 64'(IDLE));
    check("rst_cyc0", 64'(cyc0), 64'd0);
    check("rst_sw0",  64'(sw0),  64'd0);
    check("rst_inj1", 64'(inj1), 64'(IDLE));
    check("rst_inj2", 64'(inj2), 64'(IDLE));
`ifdef VERINJECT_SINGLE_PASS_EN
    check("rst_done2", 64'(done2), 64'd0);
`endif
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Free run: default schedule through one sweep wrap, plus small configs
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      check("run_cyc0", 64'(cyc0), 64'(c));
      check("run_inj0", 64'(inj0), 64'(exp0(c)));
      check("run_sw0",  64'(sw0),  (c >= 777) ? 64'd1 : 64'd0);
      if (c <= 8) check("b2b_inj1", 64'(inj1), 64'(exp1(c)));
      if (c <= 12) begin
        check("sp_inj2", 64'(inj2), 64'(exp2(c)));
        check("sp_sw2",  64'(sw2),  (c >= 8) ? 64'd1 : 64'd0);
`ifdef VERINJECT_SINGLE_PASS_EN
        check("sp_done2", 64'(done2), (c >= 8) ? 64'd1 : 64'd0);
`endif
      end
      $display("run c=%0d cyc0=%0d inj0=%0h sw0=%0d inj1=%0h inj2=%0h",
               c, cyc0, inj0, sw0, inj1, inj2);
    end

    // Restart dut0 and pause it from cycle 20 for 10 cycles
    rst_a = 1'b1;
    @(negedge clk);
    check("rst2_cyc0", 64'(cyc0), 64'd0);
    check("rst2_inj0", 64'(inj0), 64'(IDLE));
    check("rst2_sw0",  64'(sw0),  64'd0);
    rst_a = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check("pause_cyc0", 64'(cyc0), 64'(c));
      check("pause_inj0", 64'(inj0),
            (c == 16) ? 64'd0 : (c == 34) ? 64'd1 : 64'(IDLE));
      $display("pause c=%0d en=%0b inj0=%0h", c, en_a, inj0);
      if (c == 20) en_a = 1'b0;
      if (c == 30) en_a = 1'b1;
    end

    // Mid-sweep reset at cycle 40
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_cyc0", 64'(cyc0), 64'd0);
    check("mid_inj0", 64'(inj0), 64'(IDLE));
    check("mid_sw0",  64'(sw0),  64'd0);
    rst_a = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check("restart_inj0", 64'(inj0), (c == 16) ? 64'd0 : 64'(IDLE));
      $display("restart c=%0d inj0=%0h", c, inj0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
